board_io_conditioner: RTL and testbench
=======================================

Name: board_io_conditioner

Overview:
Parametrised front-end between raw board controls and the pipelined core's memory-mapped I/O. It synchronises and debounces N_SW switches and N_KEY push-buttons, normalises key polarity to active-high, and packs them into the core's i_io_sw word. It also emits one-cycle key press/release pulses and a switch-change pulse. It stretches the core's one-cycle o_insn_vld activity pulse into a visible LED drive. It sits in the board top level, clocked by the divided core clock.

Parameters:
N_SW, 10, number of slide switches (1..16)
N_KEY, 4, number of push-buttons (1..8)
OUT_W, 32, packed output width; must be >= N_SW+N_KEY
SYNC_STAGES, 2, synchroniser flops per input (>=2)
DEBOUNCE_CYCLES, 200000, consecutive stable cycles required to accept a change (>=1; 20 ms at 10 MHz)
SW_DEBOUNCE, 1, 1 = switches debounced; 0 = switches synchronised only
KEY_ACTIVE_LOW, 1, 1 = raw key pressed level is 0
STRETCH_CYCLES, 1000000, activity LED hold time in cycles (>=1)

Ports:
i_clk  input  1  core clock; all state on rising edge
i_reset  input  1  synchronous, active-high reset
i_sw  input  N_SW  raw switches, asynchronous to i_clk
i_key  input  N_KEY  raw buttons, asynchronous, polarity per KEY_ACTIVE_LOW
i_activity  input  1  activity pulse from core (o_insn_vld)
o_io_sw  output  OUT_W  packed {zeros, key_pressed[N_KEY-1:0], sw_stable[N_SW-1:0]}
o_key_press  output  N_KEY  one-cycle pulse per key on debounced press
o_key_release  output  N_KEY  one-cycle pulse per key on debounced release
o_sw_change  output  1  one-cycle pulse when any debounced switch changes
o_activity_led  output  1  stretched activity indicator

Behaviour:
- Reset (synchronous, active-high): sync chains load the inactive raw level (0 for switches; 1 for keys if KEY_ACTIVE_LOW, else 0). Debounce counters = 0. sw_stable = 0. key_pressed = 0. All pulse outputs = 0. Stretch counter = 0, so o_activity_led = 0. No press/release/change pulse on the first cycle after reset deasserts.
- Sync: each bit passes through SYNC_STAGES flops. The last stage is "synced". Keys are inverted after sync when KEY_ACTIVE_LOW=1.
- Debounce, per channel independently. Channel has a counter cnt and a stable bit st.
  - synced == st: cnt <= 0.
  - synced != st and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - synced != st and cnt == DEBOUNCE_CYCLES-1: st <= synced; cnt <= 0.
  - Any bounce back to st before acceptance clears cnt. Acceptance needs DEBOUNCE_CYCLES consecutive mismatching cycles.
  - Latency from first rising edge that samples the new raw level to st changing = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - cnt width = $clog2(DEBOUNCE_CYCLES+1). cnt never wraps.
- SW_DEBOUNCE=0: sw_stable <= synced every cycle, giving latency SYNC_STAGES+1. Keys are always debounced.
- Pulses are registered and asserted in the same cycle the new st value is first visible on o_io_sw, for exactly one cycle.
  - o_key_press[i]: key st 0->1.
  - o_key_release[i]: key st 1->0.
  - o_sw_change: OR of all switch st transitions.
  - Simultaneous transitions on several channels produce simultaneous pulses.
- o_io_sw bits [OUT_W-1:N_SW+N_KEY] are tied to 0.
- Stretcher (retriggerable):
  - i_activity=1: scnt <= STRETCH_CYCLES.
  - i_activity=0 and scnt != 0: scnt <= scnt-1.
  - o_activity_led = (scnt != 0), registered. The LED rises the cycle after the first pulse and falls STRETCH_CYCLES cycles after the last pulse.
  - i_activity held high keeps the LED on indefinitely.
- Reset mid-debounce or mid-stretch discards partial counts. The next-cycle state is the reset state.
- No handshake; outputs are valid every cycle.

Test Plan:
- Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8, N_SW=10, N_KEY=4.
- Reset: hold i_reset 3 cycles with i_key=4'hF, i_sw=0 -> o_io_sw=0, o_activity_led=0, all pulses 0; still 0 for 10 cycles after release.
- Clean press: i_key[0] 1->0 held -> o_io_sw[10]=1 exactly 6 cycles later, o_key_press=4'b0001 for one cycle; release -> o_key_release=4'b0001 one cycle, bit 10 clears 6 cycles after release.
- Bounce: i_sw[3] toggles 1,0,1,0 every 2 cycles then holds 1 -> exactly one o_sw_change pulse, o_io_sw[3]=1 six cycles after final edge, no intermediate glitch.
- Simultaneous: i_sw=10'h3FF and i_key=4'h0 on the same edge -> o_io_sw=32'h3FFF and o_key_press=4'hF on the same cycle, single o_sw_change pulse.
- Stretch retrigger: i_activity pulses at cycles 0 and 5 -> o_activity_led high from cycle 1 through cycle 13, low at cycle 14.
- Reset mid-count: i_sw[0]=1 for 3 cycles after sync, then i_reset for 1 cycle, i_sw[0] stays 1 -> st changes only a full 2+4 cycles after reset deasserts.

Source files
------------

// File: rtl/board_io_conditioner.sv
// Board control front-end: synchronises and debounces switches and keys, packs
// them for the core's I/O word, emits edge pulses and stretches the activity LED.
module board_io_conditioner #(
    parameter int unsigned N_SW            = 10,
    parameter int unsigned N_KEY           = 4,
    parameter int unsigned OUT_W           = 32,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned SW_DEBOUNCE     = 1,
    parameter int unsigned KEY_ACTIVE_LOW  = 1,
    parameter int unsigned STRETCH_CYCLES  = 1000000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_SW-1:0]  i_sw,
    input  logic [N_KEY-1:0] i_key,
    input  logic             i_activity,
    output logic [OUT_W-1:0] o_io_sw,
    output logic [N_KEY-1:0] o_key_press,
    output logic [N_KEY-1:0] o_key_release,
    output logic             o_sw_change,
    output logic             o_activity_led
);

    localparam int unsigned N_CH  = N_SW + N_KEY;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned STR_W = $clog2(STRETCH_CYCLES + 1);

    // Raw idle level per channel; also the mask that makes keys active-high.
    localparam logic [N_KEY-1:0] KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? {N_KEY{1'b1}} : {N_KEY{1'b0}};
    localparam logic [N_CH-1:0]  RAW_IDLE = {KEY_IDLE, {N_SW{1'b0}}};

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  synced;
    logic [N_CH-1:0]  mismatch;
    logic [N_CH-1:0]  accept;
    logic [N_CH-1:0]  st;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [STR_W-1:0] scnt;
    logic [STR_W-1:0] scnt_next;

    // Synchroniser chains, reset to the inactive raw level so no pulse follows reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RAW_IDLE;
            end
        end else begin
            sync_q[0] <= {i_key, i_sw};
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1] ^ RAW_IDLE;

    // Acceptance of a new level per channel; undebounced switches accept at once.
    always_comb begin
        mismatch = synced ^ st;
        accept   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (i < N_SW && SW_DEBOUNCE == 0) begin
                accept[i] = mismatch[i];
            end else begin
                accept[i] = mismatch[i] && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
            end
        end
    end

    // Debounce counters, stable levels and the edge pulses that coincide with them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            st            <= '0;
            o_key_press   <= '0;
            o_key_release <= '0;
            o_sw_change   <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (accept[i]) begin
                    st[i]  <= synced[i];
                    cnt[i] <= '0;
                end else if (mismatch[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    cnt[i] <= '0;
                end
            end
            o_key_press   <= accept[N_CH-1:N_SW] &  synced[N_CH-1:N_SW];
            o_key_release <= accept[N_CH-1:N_SW] & ~synced[N_CH-1:N_SW];
            o_sw_change   <= |accept[N_SW-1:0];
        end
    end

    assign o_io_sw = OUT_W'(st);

    // Retriggerable stretch counter next value.
    always_comb begin
        scnt_next = scnt;
        if (i_activity) begin
            scnt_next = STR_W'(STRETCH_CYCLES);
        end else if (scnt != '0) begin
            scnt_next = scnt - 1'b1;
        end
    end

    // Stretch counter and LED flop, LED tracks the counter being non-zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            scnt           <= '0;
            o_activity_led <= 1'b0;
        end else begin
            scnt           <= scnt_next;
            o_activity_led <= (scnt_next != '0);
        end
    end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Directed bench for board_io_conditioner with a cycle-stamped event scoreboard.
module tb_board_io_conditioner;

    logic        clk;
    logic        rst;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic        act;
    logic [31:0] io_sw;
    logic [3:0]  key_press;
    logic [3:0]  key_release;
    logic        sw_change;
    logic        led;

    board_io_conditioner #(
        .N_SW(10), .N_KEY(4), .OUT_W(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .SW_DEBOUNCE(1), .KEY_ACTIVE_LOW(1), .STRETCH_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_sw(sw), .i_key(key), .i_activity(act),
        .o_io_sw(io_sw), .o_key_press(key_press), .o_key_release(key_release),
        .o_sw_change(sw_change), .o_activity_led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [31:0] io;
        logic [3:0]  pr;
        logic [3:0]  rl;
        logic        ch;
    } ev_t;

    ev_t         q[$];
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_io = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_ev(input int at, input logic [31:0] io, input logic [3:0] pr,
                           input logic [3:0] rl, input logic ch);
        ev_t e;
        e.at = at; e.io = io; e.pr = pr; e.rl = rl; e.ch = ch;
        q.push_back(e);
    endtask

    // Advance n cycles, comparing every output against the scoreboard.
    task automatic run_check(input int n);
        ev_t        e;
        logic [3:0] epr;
        logic [3:0] erl;
        logic       ech;
        for (int k = 0; k < n; k++) begin
            tick();
            epr = '0; erl = '0; ech = 1'b0;
            while (q.size() > 0 && q[0].at < cyc) begin
                e = q.pop_front();
                chk("event_due", 32'(cyc), 32'(e.at));
                exp_io = e.io;
            end
            if (q.size() > 0 && q[0].at == cyc) begin
                e = q.pop_front();
                exp_io = e.io; epr = e.pr; erl = e.rl; ech = e.ch;
            end
            chk("io_sw", io_sw, exp_io);
            chk("key_press", 32'(key_press), 32'(epr));
            chk("key_release", 32'(key_release), 32'(erl));
            chk("sw_change", 32'(sw_change), 32'(ech));
            chk("led_idle", 32'(led), 32'd0);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; sw = '0; key = 4'hF; act = 1'b0;

        // Reset held three cycles.
        repeat (3) tick();
        chk("rst_io", io_sw, 32'h0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_pulses", 32'({key_press, key_release, sw_change}), 32'd0);
        rst = 1'b0;
        run_check(10);

        // Clean press and release of key 0.
        key = 4'b1110;
        push_ev(cyc + 6, 32'h0000_0400, 4'b0001, 4'b0000, 1'b0);
        run_check(10);
        key = 4'hF;
        push_ev(cyc + 6, 32'h0, 4'b0000, 4'b0001, 1'b0);
        run_check(10);

        // Bouncing switch 3, settles high.
        sw = 10'h008; run_check(2);
        sw = 10'h000; run_check(2);
        sw = 10'h008; run_check(2);
        sw = 10'h000; run_check(2);
        sw = 10'h008;
        push_ev(cyc + 6, 32'h0000_0008, 4'b0000, 4'b0000, 1'b1);
        run_check(10);

        // Everything changes on the same edge, then everything returns.
        sw = 10'h3FF; key = 4'h0;
        push_ev(cyc + 6, 32'h0000_3FFF, 4'hF, 4'h0, 1'b1);
        run_check(10);
        sw = 10'h000; key = 4'hF;
        push_ev(cyc + 6, 32'h0, 4'h0, 4'hF, 1'b1);
        run_check(10);

        // Reset in the middle of a switch debounce discards the partial count.
        sw = 10'h001;
        run_check(5);
        rst = 1'b1;
        tick();
        chk("midrst_io", io_sw, 32'h0);
        chk("midrst_change", 32'(sw_change), 32'd0);
        rst = 1'b0;
        push_ev(cyc + 6, 32'h0000_0001, 4'h0, 4'h0, 1'b1);
        run_check(10);
        sw = 10'h000;
        push_ev(cyc + 6, 32'h0, 4'h0, 4'h0, 1'b1);
        run_check(10);

        // Retriggered stretch: pulses in cycles 0 and 5, LED on 1..13.
        chk("led_before", 32'(led), 32'd0);
        for (int k = 0; k < 20; k++) begin
            act = (k == 0 || k == 5);
            tick();
            n = k + 1;
            chk("led_retrig", 32'(led), 32'((n >= 1 && n <= 13) ? 1 : 0));
        end

        // Held activity keeps LED on; it falls 8 cycles after release.
        act = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("led_held", 32'(led), 32'd1);
        end
        for (int k = 0; k < 12; k++) begin
            act = 1'b0;
            tick();
            n = k + 1;
            chk("led_fall", 32'(led), 32'((n <= 7) ? 1 : 0));
        end

        // Reset in the middle of a stretch clears the LED immediately.
        act = 1'b1; tick(); act = 1'b0; tick();
        chk("led_pre_rst", 32'(led), 32'd1);
        rst = 1'b1; tick();
        chk("led_in_rst", 32'(led), 32'd0);
        rst = 1'b0; tick();
        chk("led_post_rst", 32'(led), 32'd0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
